// File: rtl/vga_pattern_gen_if.sv
// Video-side bundle of vga_pattern_gen: pattern select in, timing/colour/counters out.
interface vga_pattern_gen_if #(
    parameter int unsigned COLOR_W = 1
);
    logic [1:0]         modein;
    logic               hout;
    logic               vout;
    logic [COLOR_W-1:0] rout;
    logic [COLOR_W-1:0] gout;
    logic [COLOR_W-1:0] bout;
    logic               aout;
    logic [15:0]        hcsout;
    logic [15:0]        vcsout;

    modport master (
        input  modein,
        output hout, vout, rout, gout, bout, aout, hcsout, vcsout
    );

    modport slave (
        output modein,
        input  hout, vout, rout, gout, bout, aout, hcsout, vcsout
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern source (stripes, checkerboard, solid).
// Optional macro VGA_PATTERN_SCROLL_EN rotates pattern colours one stripe per frame.
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SYNC_POL = 0,
    parameter int unsigned COLOR_W  = 1,
    parameter int unsigned STRIPE_W = 80
) (
    input  logic              clkin,
    input  logic              rstin,
    vga_pattern_gen_if.master vif
);
    localparam int unsigned CW       = 16;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG   = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG   = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_BEG + V_SYNC;
    localparam int unsigned SW       = (STRIPE_W > 1) ? $clog2(STRIPE_W) : 1;
    localparam logic        SYNC_ACT = 1'(SYNC_POL);

    logic [CW-1:0]      hcs, vcs;
    logic [SW-1:0]      cx, cy;
    logic [2:0]         kx, ky;
    logic [1:0]         mode_q;
    logic               hout_q, vout_q, aout_q;
    logic [COLOR_W-1:0] r_q, g_q, b_q;

    logic               h_wrap_c, v_wrap_c, frame_wrap_c, origin_c;
    logic               active_c, hs_c, vs_c;
    logic [1:0]         mode_c;
    logic [2:0]         colour_c, seed_c;

    assign h_wrap_c     = (hcs == CW'(H_TOTAL - 1));
    assign v_wrap_c     = (vcs == CW'(V_TOTAL - 1));
    assign frame_wrap_c = h_wrap_c && v_wrap_c;
    assign origin_c     = (hcs == '0) && (vcs == '0);

`ifdef VGA_PATTERN_SCROLL_EN
    logic [2:0] fc;

    // Frame counter; the stripe index restarts from the incoming frame's value.
    always_ff @(posedge clkin) begin
        if (rstin)
            fc <= '0;
        else if (frame_wrap_c)
            fc <= fc + 3'd1;
    end

    assign seed_c = frame_wrap_c ? (fc + 3'd1) : fc;
`else
    assign seed_c = 3'd0;
`endif

    // Mode is latched at the frame origin; that first pixel already uses the new value.
    assign mode_c = origin_c ? vif.modein : mode_q;

    always_comb begin
        active_c = (hcs < CW'(H_ACTIVE)) && (vcs < CW'(V_ACTIVE));
        hs_c     = (hcs >= CW'(HS_BEG)) && (hcs < CW'(HS_END));
        vs_c     = (vcs >= CW'(VS_BEG)) && (vcs < CW'(VS_END));
        colour_c = 3'd0;
        case (mode_c)
            2'b00:   colour_c = kx;
            2'b01:   colour_c = ky;
            2'b10:   colour_c = (kx[0] ^ ky[0]) ? 3'b111 : 3'b000;
            default: colour_c = 3'b111;
        endcase
    end

    // Raster counters.
    always_ff @(posedge clkin) begin
        if (rstin) begin
            hcs <= '0;
            vcs <= '0;
        end else begin
            hcs <= h_wrap_c ? '0 : hcs + CW'(1);
            if (h_wrap_c)
                vcs <= v_wrap_c ? '0 : vcs + CW'(1);
        end
    end

    // Stripe indices track hcs/vcs divided by STRIPE_W without a divider.
    always_ff @(posedge clkin) begin
        if (rstin) begin
            cx <= '0;
            kx <= '0;
            cy <= '0;
            ky <= '0;
        end else begin
            if (h_wrap_c) begin
                cx <= '0;
                kx <= seed_c;
            end else if (cx == SW'(STRIPE_W - 1)) begin
                cx <= '0;
                kx <= kx + 3'd1;
            end else begin
                cx <= cx + SW'(1);
            end

            if (h_wrap_c) begin
                if (v_wrap_c) begin
                    cy <= '0;
                    ky <= seed_c;
                end else if (cy == SW'(STRIPE_W - 1)) begin
                    cy <= '0;
                    ky <= ky + 3'd1;
                end else begin
                    cy <= cy + SW'(1);
                end
            end
        end
    end

    // Registered decode: outputs describe the counter state of the previous clock.
    always_ff @(posedge clkin) begin
        if (rstin) begin
            mode_q <= 2'b00;
            hout_q <= ~SYNC_ACT;
            vout_q <= ~SYNC_ACT;
            aout_q <= 1'b0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            mode_q <= mode_c;
            hout_q <= hs_c ? SYNC_ACT : ~SYNC_ACT;
            vout_q <= vs_c ? SYNC_ACT : ~SYNC_ACT;
            aout_q <= active_c;
            r_q    <= active_c ? {COLOR_W{colour_c[2]}} : '0;
            g_q    <= active_c ? {COLOR_W{colour_c[1]}} : '0;
            b_q    <= active_c ? {COLOR_W{colour_c[0]}} : '0;
        end
    end

    assign vif.hout   = hout_q;
    assign vif.vout   = vout_q;
    assign vif.aout   = aout_q;
    assign vif.rout   = r_q;
    assign vif.gout   = g_q;
    assign vif.bout   = b_q;
    assign vif.hcsout = hcs;
    assign vif.vcsout = vcs;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a reduced 24x16 raster with 4-pixel stripes.
module tb_vga_pattern_gen;
    localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VA = 12, VF = 1, VS = 2, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned CWID = 2;
`ifdef VGA_PATTERN_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;
    int   frm = 0;

    always #5 clk = ~clk;

    vga_pattern_gen_if #(.COLOR_W(CWID)) vif ();

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .COLOR_W(CWID), .STRIPE_W(4)
    ) dut (
        .clkin (clk),
        .rstin (rst),
        .vif   (vif.master)
    );

    // Frames elapsed since reset, for scroll-offset expectations.
    always @(posedge clk) begin
        if (rst)
            frm <= 0;
        else if (vif.hcsout == 16'(HT - 1) && vif.vcsout == 16'(VT - 1))
            frm <= frm + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] sc();
        return SCROLL ? 3'(frm) : 3'd0;
    endfunction

    function automatic logic [5:0] col(input logic [2:0] c);
        return {{2{c[2]}}, {2{c[1]}}, {2{c[0]}}};
    endfunction

    function automatic logic [5:0] rgb();
        return {vif.rout, vif.gout, vif.bout};
    endfunction

    task automatic goto(input int h, input int v);
        int k   = 0;
        bit hit = 1'b0;
        while (!hit && k < 1000) begin
            @(negedge clk);
            k++;
            hit = (vif.hcsout == 16'(h)) && (vif.vcsout == 16'(v));
        end
        chk("goto", 32'(hit), 32'd1);
    endtask

    // Outputs seen at counter (h+1,v) describe pixel (h,v).
    task automatic pix(input string tag, input int h, input int v,
                       input logic exp_a, input logic [5:0] exp_rgb);
        goto(h + 1, v);
        chk({tag, "_a"}, 32'(vif.aout), 32'(exp_a));
        chk({tag, "_rgb"}, 32'(rgb()), 32'(exp_rgb));
    endtask

    initial begin
        int cnt, first, k;
        vif.modein = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_h", 32'(vif.hout), 32'd1);
        chk("rst_v", 32'(vif.vout), 32'd1);
        chk("rst_a", 32'(vif.aout), 32'd0);
        chk("rst_rgb", 32'(rgb()), 32'd0);
        chk("rst_hcs", 32'(vif.hcsout), 32'd0);
        chk("rst_vcs", 32'(vif.vcsout), 32'd0);
        rst = 1'b0;

        // Frame 0, vertical stripes on line 0.
        @(negedge clk);
        chk("rel_hcs", 32'(vif.hcsout), 32'd1);
        chk("rel_a", 32'(vif.aout), 32'd1);
        chk("rel_rgb", 32'(rgb()), 32'd0);
        pix("vs_px4", 4, 0, 1'b1, 6'b000011);
        pix("vs_px8", 8, 0, 1'b1, 6'b001100);
        pix("vs_px12", 12, 0, 1'b1, 6'b001111);
        pix("vs_px15", 15, 0, 1'b1, 6'b001111);
        pix("vs_px16", 16, 0, 1'b0, 6'b000000);

        // hsync covers pixels 18..20, observed at hcsout 19..21.
        cnt = 0; first = -1;
        for (int i = 0; i < int'(HT); i++) begin
            @(negedge clk);
            if (vif.hout == 1'b0) begin
                cnt++;
                if (first < 0) first = int'(vif.hcsout);
            end
        end
        chk("hs_len", 32'(cnt), 32'd3);
        chk("hs_first", 32'(first), 32'd19);

        // vsync covers lines 13..14; frame period HT*VT.
        goto(0, 0);
        cnt = 0; first = -1; k = 0;
        do begin
            @(negedge clk);
            k++;
            if (vif.vout == 1'b0) begin
                cnt++;
                if (first < 0) first = int'({vif.vcsout, vif.hcsout});
            end
        end while (!(vif.hcsout == 16'd0 && vif.vcsout == 16'd0) && k < 1000);
        chk("frame_len", 32'(k), 32'(HT * VT));
        chk("vs_len", 32'(cnt), 32'(2 * HT));
        chk("vs_first", 32'(first), {16'd13, 16'd1});

        // Frame 2: checkerboard (latched at this origin).
        vif.modein = 2'b10;
        pix("ck_00", 0, 0, 1'b1, 6'b000000);
        pix("ck_40", 4, 0, 1'b1, 6'b111111);
        pix("ck_04", 0, 4, 1'b1, 6'b111111);
        pix("ck_44", 4, 4, 1'b1, 6'b000000);
        vif.modein = 2'b01;
        pix("ck_mid", 8, 5, 1'b1, 6'b111111);
        pix("ck_88", 8, 8, 1'b1, 6'b000000);

        // Frame 3: horizontal stripes.
        pix("hs_l4a", 0, 4, 1'b1, col(3'd1 + sc()));
        pix("hs_l4b", 9, 4, 1'b1, col(3'd1 + sc()));
        pix("hs_l8", 0, 8, 1'b1, col(3'd2 + sc()));
        pix("hs_l12", 0, 12, 1'b0, 6'b000000);
        vif.modein = 2'b00;

        // Frame 4: switch to solid mid-frame, stripes persist.
        goto(0, 6);
        vif.modein = 2'b11;
        pix("sw_keep", 4, 8, 1'b1, col(3'd1 + sc()));

        // Frame 5: solid white.
        pix("sol_00", 0, 0, 1'b1, 6'b111111);
        pix("sol_40", 4, 0, 1'b1, 6'b111111);
        pix("sol_last", 15, 11, 1'b1, 6'b111111);
        pix("sol_blank", 16, 11, 1'b0, 6'b000000);
        vif.modein = 2'b00;

        // Frames 6..8: pixel 0 colour, static unless scrolling.
        pix("f6_px0", 0, 0, 1'b1, col(SCROLL ? 3'd6 : 3'd0));
        pix("f7_px0", 0, 0, 1'b1, col(SCROLL ? 3'd7 : 3'd0));
        pix("f8_px0", 0, 0, 1'b1, col(3'd0));
        pix("f8_px4", 4, 0, 1'b1, col(3'd1));

        // Mid-line reset.
        goto(10, 3);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_hcs", 32'(vif.hcsout), 32'd0);
        chk("mrst_vcs", 32'(vif.vcsout), 32'd0);
        chk("mrst_h", 32'(vif.hout), 32'd1);
        chk("mrst_v", 32'(vif.vout), 32'd1);
        chk("mrst_a", 32'(vif.aout), 32'd0);
        chk("mrst_rgb", 32'(rgb()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrel_hcs", 32'(vif.hcsout), 32'd1);
        chk("mrel_a", 32'(vif.aout), 32'd1);
        pix("mrel_px4", 4, 0, 1'b1, 6'b000011);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised successor of the fixed-timing VGA stripe generator.
- Produces VGA timing (hsync, vsync, active-video) at any resolution and sync polarity, plus a selectable test pattern: vertical stripes, horizontal stripes, checkerboard or solid.
- Colour depth per channel is configurable.
- Sits directly behind the pixel clock as the top-level video source driving the board's VGA DAC/resistor network.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
- COLOR_W, 1, bits per colour channel
- STRIPE_W, 80, stripe/cell size in pixels (horizontal) and lines (vertical); any value ≥1

Ports:
- clkin  in  1  pixel clock
- rstin  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
- modein  in  2  pattern select: 00 vertical stripes, 01 horizontal stripes, 10 checkerboard, 11 solid white
- hout  out  1  horizontal sync
- vout  out  1  vertical sync
- rout  out  COLOR_W  red
- gout  out  COLOR_W  green
- bout  out  COLOR_W  blue
- aout  out  1  active-video flag
- hcsout  out  16  horizontal counter (raw)
- vcsout  out  16  vertical counter (raw)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- hcs counts 0..H_TOTAL-1 every clkin and wraps to 0. vcs increments only on the hcs wrap and wraps 0..V_TOTAL-1.
- hcsout/vcsout expose the counters directly, zero-extended to 16 bits.
- Reset (rstin=1 at clkin edge):
  - hcs=vcs=0; stripe counters=0; mode register=00.
  - aout=0; rout/gout/bout=0.
  - hout=vout=~SYNC_POL (inactive).
  - Reset mid-line or mid-frame restarts the frame at (0,0) on the next edge.
- Pipeline: hout, vout, aout and RGB are registered decodes of the counter state. The value at cycle n+1 describes (hcs,vcs) at cycle n, giving 1 clock latency versus hcsout/vcsout.
- Decode for counter state (h,v):
  - active = h<H_ACTIVE && v<V_ACTIVE
  - hsync asserted (=SYNC_POL) for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vsync asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for the whole of those lines
- Stripe indexing (no dividers):
  - Column sub-counter cx counts 0..STRIPE_W-1. On wrap, column index kx increments (3 bits, wraps mod 8). Both clear at h=0.
  - Row sub-counter cy/ky behaves the same per line, advancing on the hcs wrap. Both clear at v=0.
- Colour index c[2:0]:
  - mode 00: c=kx
  - mode 01: c=ky
  - mode 10: c = (kx[0]^ky[0]) ? 3'b111 : 3'b000
  - mode 11: c=3'b111
- Channel outputs:
  - rout = {COLOR_W{c[2]}}, gout = {COLOR_W{c[1]}}, bout = {COLOR_W{c[0]}}
  - Forced to 0 whenever active=0.
- modein is sampled into the mode register only when (h,v)=(0,0). Mid-frame changes take effect at the next frame start.
- STRIPE_W > H_ACTIVE: index never advances within a line (whole line uses index 0). Same rule applies vertically.

Optional Feature:
- Macro: VGA_PATTERN_SCROLL_EN.
- Defined:
  - 3-bit frame counter fc increments when vcs wraps V_TOTAL-1→0. Reset to 0.
  - kx is seeded with fc at each h=0 instead of 0, and ky is seeded with fc at v=0, so the pattern colours rotate one stripe per frame.
- Undefined: fc does not exist; seeds are 0; the pattern is static.

Test Plan:
- Hold rstin 3 clocks, release → hout=vout=1, aout=0, RGB=0 during reset; hcsout=1 one clock after release; aout=1 on the clock after hcsout=1 (latency 1).
- Defaults, sync timing → hout low for exactly 96 clocks, while hcsout=657..752 (h=656..751 delayed); vout low for exactly 2×800 clocks; frame period 420000 clocks.
- modein=00, line 0 → pixels 0–79 RGB=000, 80–159 =001 (blue), 160–239 =010, …, 560–639 =111; pixels 640–799 RGB=000 and aout=0.
- modein=10 → pixel (0,0) black, (80,0) white, (0,80) white, (80,80) black; modein=01 → line 80 blue throughout.
- Change modein 00→11 at vcs=100 → rest of frame stays striped; next frame solid white (RGB=111 on all active pixels). Assert rstin mid-line at hcs=300 → next cycle hcsout=0, vcsout=0, outputs at reset values.
- With VGA_PATTERN_SCROLL_EN, mode 00 → frame 0 pixel 0 =000, frame 1 pixel 0 =001, frame 8 pixel 0 =000 (wrap); without the macro all frames are identical.
